// File: rtl/trigger_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_capture_pkg
//  Description : Shared constants for the trigger capture controller: state
//                encoding, event-tag bit indices and register addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
package trigger_capture_pkg;

    // Capture state encoding (also reported on sts_state)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_POST  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Bit positions inside the event tag from the trigger stage
    localparam int EVT_TRG = 0;
    localparam int EVT_ABT = 1;

    // Register addresses (bus_waddr[1:0])
    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_PRE  = 2'd1;
    localparam logic [1:0] REG_POST = 2'd2;

    // CTRL write-1 pulse bits
    localparam int CTRL_ARM    = 0;
    localparam int CTRL_DISARM = 1;

    // A capture is in progress (samples are being forwarded)
    function automatic logic is_running(input logic [1:0] st);
        return (st == ST_ARMED) || (st == ST_POST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/trigger_capture_stage.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_capture_stage
//  Description : Single-entry valid/ready output register carrying a sample
//                and its last flag. force_last marks the held beat as the
//                final one (used when a capture is aborted).
//  Revision    : 1.0 - initial release
// ============================================================================
module trigger_capture_stage #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    input  logic          force_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;
    logic          last_q,  last_d;

    // Stage register; reset drops any held beat immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    // Load a new beat, drain on acceptance, or latch a forced last on a held beat
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (in_valid && in_ready) begin
            valid_d = 1'b1;
            data_d  = in_data;
            last_d  = in_last;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end else if (force_last && valid_q) begin
            last_d  = 1'b1;
        end
    end

    // The forced last is also visible combinationally so a beat leaving in
    // the very cycle of the abort still carries tlast
    always_comb begin
        in_ready  = out_ready | ~valid_q;
        out_valid = valid_q;
        out_data  = data_q;
        out_last  = last_q | (force_last & valid_q);
    end

endmodule
`default_nettype wire

// File: rtl/trigger_capture.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_capture
//  Description : Capture controller downstream of the trigger stage. Armed by
//                bus command, enforces a minimum pre-trigger depth, forwards
//                a programmed number of post-trigger samples and marks the
//                final one with tlast.
//  Options     : TRIGGER_CAPTURE_TRGPOS_EN adds sts_trg_pos (samples
//                forwarded before the accepted trigger sample).
//  Revision    : 1.0 - initial release
// ============================================================================
module trigger_capture
    import trigger_capture_pkg::*;
#(
    parameter int BAW = 6,
    parameter int BDW = 32,
    parameter int SDW = 32,
    parameter int SEW = 2,
    parameter int CCW = 32
) (
    input  logic           clk,
    input  logic           rst,
    output logic           bus_wready,
    input  logic           bus_wvalid,
    input  logic [BAW-1:0] bus_waddr,
    input  logic [BDW-1:0] bus_wdata,
    output logic           sti_tready,
    input  logic           sti_tvalid,
    input  logic [SEW-1:0] sti_tevent,
    input  logic [SDW-1:0] sti_tdata,
    input  logic           sto_tready,
    output logic           sto_tvalid,
    output logic           sto_tlast,
    output logic [SDW-1:0] sto_tdata,
    output logic [1:0]     sts_state,
    output logic           sts_done,
    output logic           sts_abort
`ifdef TRIGGER_CAPTURE_TRGPOS_EN
    ,
    output logic [CCW-1:0] sts_trg_pos
`endif
);

    logic [1:0]     state_q,    state_d;
    logic [CCW-1:0] pre_cfg_q,  pre_cfg_d;
    logic [CCW-1:0] post_cfg_q, post_cfg_d;
    logic [CCW-1:0] pre_lim_q,  pre_lim_d;
    logic [CCW-1:0] pre_cnt_q,  pre_cnt_d;
    logic [CCW-1:0] post_cnt_q, post_cnt_d;
    logic           done_q,     done_d;
    logic           abort_q,    abort_d;
    logic           live_q,     live_d;
`ifdef TRIGGER_CAPTURE_TRGPOS_EN
    logic [CCW-1:0] fwd_cnt_q,  fwd_cnt_d;
    logic [CCW-1:0] trg_pos_q,  trg_pos_d;
`endif

    logic w_wr_ctrl, w_arm_req, w_disarm_req, w_running;
    logic w_xfer, w_abort, w_trg_hit, w_fwd, w_fwd_last, w_stg_in_ready;

    // Upper address bits and spare data bits are not decoded
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus_waddr[BAW-1:2];
    generate
        if (BDW > CCW) begin : g_wdata_spare
            logic unused_wdata_bits;
            assign unused_wdata_bits = ^bus_wdata[BDW-1:CCW];
        end
    endgenerate

    assign w_wr_ctrl    = bus_wvalid && (bus_waddr[1:0] == REG_CTRL);
    assign w_arm_req    = w_wr_ctrl & bus_wdata[CTRL_ARM];
    assign w_disarm_req = w_wr_ctrl & bus_wdata[CTRL_DISARM];
    assign w_running    = is_running(state_q);
    assign w_xfer       = sti_tvalid & sti_tready;
    // Abort (tag or disarm) dominates: the aborting sample is never forwarded
    assign w_abort      = w_running & ((w_xfer & sti_tevent[EVT_ABT]) | w_disarm_req);
    assign w_fwd        = w_running & w_xfer & ~w_abort;
    assign w_trg_hit    = (state_q == ST_ARMED) & w_fwd & sti_tevent[EVT_TRG]
                          & (pre_cnt_q == pre_lim_q);

    // State, configuration and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pre_cfg_q  <= '0;
            post_cfg_q <= '0;
            pre_lim_q  <= '0;
            pre_cnt_q  <= '0;
            post_cnt_q <= '0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            live_q     <= 1'b0;
`ifdef TRIGGER_CAPTURE_TRGPOS_EN
            fwd_cnt_q  <= '0;
            trg_pos_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pre_cfg_q  <= pre_cfg_d;
            post_cfg_q <= post_cfg_d;
            pre_lim_q  <= pre_lim_d;
            pre_cnt_q  <= pre_cnt_d;
            post_cnt_q <= post_cnt_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            live_q     <= live_d;
`ifdef TRIGGER_CAPTURE_TRGPOS_EN
            fwd_cnt_q  <= fwd_cnt_d;
            trg_pos_q  <= trg_pos_d;
`endif
        end
    end

    // Next state: register writes, arming, pre/post counting and abort
    always_comb begin
        state_d    = state_q;
        pre_cfg_d  = pre_cfg_q;
        post_cfg_d = post_cfg_q;
        pre_lim_d  = pre_lim_q;
        pre_cnt_d  = pre_cnt_q;
        post_cnt_d = post_cnt_q;
        done_d     = done_q;
        abort_d    = abort_q;
        live_d     = 1'b1;
        w_fwd_last = 1'b0;
`ifdef TRIGGER_CAPTURE_TRGPOS_EN
        fwd_cnt_d  = fwd_cnt_q;
        trg_pos_d  = trg_pos_q;
`endif

        if (bus_wvalid && (bus_waddr[1:0] == REG_PRE))  pre_cfg_d  = bus_wdata[CCW-1:0];
        if (bus_wvalid && (bus_waddr[1:0] == REG_POST)) post_cfg_d = bus_wdata[CCW-1:0];
        // Flag clear comes first so a completion/abort in the same cycle still sets it
        if (w_wr_ctrl) begin
            done_d  = 1'b0;
            abort_d = 1'b0;
        end

        case (state_q)
            ST_ARMED: begin
                if (w_abort) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else if (w_fwd) begin
                    if (pre_cnt_q != pre_lim_q) pre_cnt_d = pre_cnt_q + CCW'(1);
`ifdef TRIGGER_CAPTURE_TRGPOS_EN
                    if (fwd_cnt_q != '1) fwd_cnt_d = fwd_cnt_q + CCW'(1);
                    if (w_trg_hit) trg_pos_d = fwd_cnt_q;
`endif
                    if (w_trg_hit) begin
                        if (post_cnt_q == '0) begin
                            w_fwd_last = 1'b1;
                            state_d    = ST_DONE;
                            done_d     = 1'b1;
                        end else begin
                            state_d    = ST_POST;
                        end
                    end
                end
            end
            ST_POST: begin
                if (w_abort) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else if (w_fwd) begin
                    if (post_cnt_q == CCW'(1)) begin
                        w_fwd_last = 1'b1;
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                    end else begin
                        post_cnt_d = post_cnt_q - CCW'(1);
                    end
                end
            end
            default: begin
                // IDLE / DONE: snapshot the configuration on arm
                if (w_arm_req) begin
                    state_d    = ST_ARMED;
                    pre_lim_d  = pre_cfg_q;
                    pre_cnt_d  = '0;
                    post_cnt_d = post_cfg_q;
`ifdef TRIGGER_CAPTURE_TRGPOS_EN
                    fwd_cnt_d  = '0;
                    trg_pos_d  = '0;
`endif
                end
            end
        endcase
    end

    // Outputs: stream backpressure follows the stage while running, otherwise
    // samples are sunk; held low until the first cycle out of reset
    always_comb begin
        bus_wready = 1'b1;
        sti_tready = live_q & (w_running ? w_stg_in_ready : 1'b1);
        sts_state  = state_q;
        sts_done   = done_q;
        sts_abort  = abort_q;
`ifdef TRIGGER_CAPTURE_TRGPOS_EN
        sts_trg_pos = trg_pos_q;
`endif
    end

    trigger_capture_stage #(
        .DW (SDW)
    ) u_stage (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (w_fwd),
        .in_ready   (w_stg_in_ready),
        .in_data    (sti_tdata),
        .in_last    (w_fwd_last),
        .force_last (w_abort),
        .out_valid  (sto_tvalid),
        .out_ready  (sto_tready),
        .out_data   (sto_tdata),
        .out_last   (sto_tlast)
    );

endmodule
`default_nettype wire

// File: tb/tb_trigger_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trigger_capture
//  Description : Directed self-checking bench for trigger_capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trigger_capture;

    localparam int BAW = 6;
    localparam int BDW = 32;
    localparam int SDW = 32;
    localparam int SEW = 2;
    localparam int CCW = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           bus_wready;
    logic           bus_wvalid;
    logic [BAW-1:0] bus_waddr;
    logic [BDW-1:0] bus_wdata;
    logic           sti_tready;
    logic           sti_tvalid;
    logic [SEW-1:0] sti_tevent;
    logic [SDW-1:0] sti_tdata;
    logic           sto_tready;
    logic           sto_tvalid;
    logic           sto_tlast;
    logic [SDW-1:0] sto_tdata;
    logic [1:0]     sts_state;
    logic           sts_done;
    logic           sts_abort;
`ifdef TRIGGER_CAPTURE_TRGPOS_EN
    logic [CCW-1:0] sts_trg_pos;
`endif

    int checks   = 0;
    int failures = 0;

    logic [SDW:0] beats[$];
    logic [SDW:0] exp_q[$];
    logic         stall_seen = 1'b0;
    logic [SDW-1:0] held_data;

    always #5 clk = ~clk;

    trigger_capture #(
        .BAW (BAW), .BDW (BDW), .SDW (SDW), .SEW (SEW), .CCW (CCW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_wready (bus_wready),
        .bus_wvalid (bus_wvalid),
        .bus_waddr  (bus_waddr),
        .bus_wdata  (bus_wdata),
        .sti_tready (sti_tready),
        .sti_tvalid (sti_tvalid),
        .sti_tevent (sti_tevent),
        .sti_tdata  (sti_tdata),
        .sto_tready (sto_tready),
        .sto_tvalid (sto_tvalid),
        .sto_tlast  (sto_tlast),
        .sto_tdata  (sto_tdata),
        .sts_state  (sts_state),
        .sts_done   (sts_done),
        .sts_abort  (sts_abort)
`ifdef TRIGGER_CAPTURE_TRGPOS_EN
        ,
        .sts_trg_pos (sts_trg_pos)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: records accepted beats and checks data hold under stall
    always @(negedge clk) begin
        if (rst) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen)
                check_eq("hold_data", {31'd0, sto_tvalid, sto_tdata}, {31'd0, 1'b1, held_data});
            if (sto_tvalid && sto_tready) beats.push_back({sto_tlast, sto_tdata});
            stall_seen = sto_tvalid && !sto_tready;
            held_data  = sto_tdata;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [BDW-1:0] d);
        bus_wvalid = 1'b1;
        bus_waddr  = {4'b0000, a};
        bus_wdata  = d;
        @(posedge clk);
        #1;
        bus_wvalid = 1'b0;
    endtask

    task automatic send(input logic [SDW-1:0] d, input logic [1:0] ev);
        int n = 0;
        sti_tvalid = 1'b1;
        sti_tdata  = d;
        sti_tevent = ev;
        @(negedge clk);
        while (!sti_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!sti_tready) check_eq("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        sti_tvalid = 1'b0;
        sti_tevent = '0;
    endtask

    task automatic check_beats(input string tag);
        int n;
        check_eq({tag, "_count"}, 64'(beats.size()), 64'(exp_q.size()));
        n = (beats.size() < exp_q.size()) ? beats.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s_beat%0d", tag, i), 64'(beats[i]), 64'(exp_q[i]));
        beats.delete();
        exp_q.delete();
    endtask

    initial begin
        rst        = 1'b1;
        bus_wvalid = 1'b0;
        bus_waddr  = '0;
        bus_wdata  = '0;
        sti_tvalid = 1'b0;
        sti_tevent = '0;
        sti_tdata  = '0;
        sto_tready = 1'b1;

        // Reset values
        #12;
        check_eq("rst_wready", 64'(bus_wready), 64'd1);
        check_eq("rst_outs", {56'd0, sti_tready, sto_tvalid, sto_tlast, sts_state, sts_done, sts_abort},
                 64'd0);
        check_eq("rst_tdata", 64'(sto_tdata), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_cycles(2);

        // T1: PRE=2 POST=3, early trigger ignored, second trigger accepted
        bus_wr(2'd1, 32'd2);
        bus_wr(2'd2, 32'd3);
        bus_wr(2'd0, 32'd1);
        check_eq("t1_armed", 64'(sts_state), 64'd1);
        for (int i = 0; i < 10; i++)
            send(SDW'(100 + i), (i == 0 || i == 4) ? 2'b01 : 2'b00);
        wait_cycles(4);
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), SDW'(100 + i)});
        check_beats("t1");
        check_eq("t1_state", 64'(sts_state), 64'd3);
        check_eq("t1_flags", {62'd0, sts_done, sts_abort}, 64'b10);
`ifdef TRIGGER_CAPTURE_TRGPOS_EN
        check_eq("t1_trgpos", 64'(sts_trg_pos), 64'd4);
`endif

        // T2: PRE=0 POST=0, trigger on first sample gives a single last beat
        bus_wr(2'd1, 32'd0);
        bus_wr(2'd2, 32'd0);
        bus_wr(2'd0, 32'd1);
        check_eq("t2_rearm_clr", {62'd0, sts_done, sts_state == 2'd1}, 64'b01);
        send(32'h200, 2'b01);
        send(32'h201, 2'b01);
        wait_cycles(4);
        exp_q.push_back({1'b1, 32'h200});
        check_beats("t2");
        check_eq("t2_state", 64'(sts_state), 64'd3);
        check_eq("t2_done", 64'(sts_done), 64'd1);

        // T3: downstream stall mid-POST
        bus_wr(2'd2, 32'd6);
        bus_wr(2'd0, 32'd1);
        send(32'd300, 2'b01);
        send(32'd301, 2'b00);
        send(32'd302, 2'b00);
        sto_tready = 1'b0;
        fork
            send(32'd303, 2'b00);
            begin
                repeat (2) @(negedge clk);
                check_eq("t3_stall", {62'd0, sti_tready, sto_tvalid}, 64'b01);
                repeat (3) @(negedge clk);
                @(posedge clk);
                #1;
                sto_tready = 1'b1;
            end
        join
        send(32'd304, 2'b00);
        send(32'd305, 2'b00);
        send(32'd306, 2'b00);
        wait_cycles(4);
        for (int i = 0; i < 7; i++) exp_q.push_back({(i == 6), SDW'(300 + i)});
        check_beats("t3");
        check_eq("t3_state", 64'(sts_state), 64'd3);

        // T4: abort tag during ARMED while a beat is stalled in the output
        bus_wr(2'd1, 32'd5);
        bus_wr(2'd2, 32'd2);
        bus_wr(2'd0, 32'd1);
        send(32'd400, 2'b00);
        send(32'd401, 2'b00);
        send(32'd402, 2'b01);
        sto_tready = 1'b0;
        fork
            send(32'd403, 2'b10);
            begin
                repeat (3) @(negedge clk);
                check_eq("t4_held", {61'd0, sts_state, sto_tlast}, {61'd0, 2'd1, 1'b0});
                @(posedge clk);
                #1;
                sto_tready = 1'b1;
            end
        join
        wait_cycles(4);
        exp_q.push_back({1'b0, 32'd400});
        exp_q.push_back({1'b0, 32'd401});
        exp_q.push_back({1'b1, 32'd402});
        check_beats("t4");
        check_eq("t4_state", 64'(sts_state), 64'd0);
        check_eq("t4_flags", {61'd0, sts_done, sts_abort, sto_tvalid}, 64'b010);

        // T5: POST rewrite during capture has no effect; re-arm from DONE
        bus_wr(2'd1, 32'd0);
        bus_wr(2'd2, 32'd2);
        bus_wr(2'd0, 32'd1);
        check_eq("t5_abort_clr", 64'(sts_abort), 64'd0);
        send(32'd500, 2'b01);
        bus_wr(2'd2, 32'd100);
        send(32'd501, 2'b00);
        send(32'd502, 2'b00);
        send(32'd503, 2'b00);
        wait_cycles(4);
        exp_q.push_back({1'b0, 32'd500});
        exp_q.push_back({1'b0, 32'd501});
        exp_q.push_back({1'b1, 32'd502});
        check_beats("t5");
        check_eq("t5_done", {62'd0, sts_state}, 64'd3);
        check_eq("t5_doneflag", 64'(sts_done), 64'd1);
        bus_wr(2'd0, 32'd1);
        check_eq("t5_rearm", {61'd0, sts_done, sts_state}, {61'd0, 1'b0, 2'd1});

        // T6: asynchronous reset while in POST with a beat held
        send(32'd600, 2'b01);
        sto_tready = 1'b0;
        wait_cycles(1);
        @(negedge clk);
        check_eq("t6_pre", {61'd0, sto_tvalid, sts_state}, {61'd0, 1'b1, 2'd2});
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_async", {59'd0, sto_tvalid, sts_state, sts_done, sts_abort}, 64'd0);
        wait_cycles(2);
        rst = 1'b0;
        sto_tready = 1'b1;
        beats.delete();
        wait_cycles(2);

        // T7: configuration cleared by reset -> PRE=0 POST=0 capture
        bus_wr(2'd0, 32'd1);
        send(32'd700, 2'b01);
        wait_cycles(4);
        exp_q.push_back({1'b1, 32'd700});
        check_beats("t7");
        check_eq("t7_state", 64'(sts_state), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
